uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Parameters
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (fixed at 4 in this revision; grant_id is 2 bits).
REQ-002 The block SHALL have parameter TIMEOUT, default 16'd2000, meaning the maximum tick count allowed in any wait state.

Interface
REQ-003 tick  input  1  clock; all logic SHALL run on its rising edge, which is the same tick that clocks the UART transmitter.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  4  request per requester; level-held until ack.
REQ-006 req_data  input  32  byte per requester; requester i uses bits [8i+7:8i].
REQ-007 ack  output  4  one-tick pulse to the granted requester when its byte is latched.
REQ-008 grant_id  output  2  index of the current or last granted requester.
REQ-009 busy  output  1  high in every state except S_IDLE.
REQ-010 tx_start  output  1  start strobe to the transmitter.
REQ-011 tx_data  output  8  byte to the transmitter.
REQ-012 tx_done  input  1  done flag from the transmitter; cleared when it accepts a start, set at the stop bit, held high until the next start.
REQ-013 timeout_err  output  1  sticky error flag.

Function
REQ-014 The FSM SHALL have five states: S_IDLE, S_START, S_WAIT_CLR, S_WAIT_DONE and S_GAP.
REQ-015 In S_IDLE with any req bit high, the block SHALL select the winner round-robin, searching upward from last_grant+1 modulo 4.
REQ-016 On the winning S_IDLE edge the block SHALL latch the winner's byte into tx_data, load the winner into grant_id and last_grant, pulse ack[winner] for exactly the next tick, and enter S_START.
REQ-017 In S_IDLE with req==0 the block SHALL remain in S_IDLE and tx_start SHALL be 0.
REQ-018 tx_start SHALL be 1 only while in S_START, and S_START SHALL last exactly one tick before S_WAIT_CLR.
REQ-019 S_WAIT_CLR SHALL wait for tx_done==0, then enter S_WAIT_DONE.
REQ-020 S_WAIT_DONE SHALL wait for tx_done==1, then enter S_GAP.
REQ-021 S_GAP SHALL last exactly one tick, then return to S_IDLE, so the transmitter is back in its idle state before the next start.
REQ-022 Latency from req rising in S_IDLE to tx_start=1 SHALL be 1 tick.
REQ-023 A requester SHALL be re-eligible only after a return to S_IDLE.
REQ-024 If req drops before grant, that requester SHALL not be served; req changes after grant SHALL have no effect on the transfer in progress.
REQ-025 tx_data SHALL hold its value from S_START through the end of S_WAIT_DONE.
REQ-026 A 16-bit wait counter SHALL clear on entry to S_WAIT_CLR and to S_WAIT_DONE, and increment each tick in those states.
REQ-027 When the wait counter reaches TIMEOUT-1 in a wait state, the block SHALL set timeout_err=1 and go to S_IDLE next tick.
REQ-028 timeout_err SHALL stay set until reset.
REQ-029 With all four req high continuously, the grant order SHALL be 0,1,2,3,0,... with no requester skipped.
REQ-030 tx_done already high on entry to S_WAIT_CLR, stale from the previous byte, SHALL NOT be taken as completion.

Reset
REQ-031 On a tick edge with rst_n==0, the block SHALL set state=S_IDLE, tx_start=0, tx_data=0, ack=0, grant_id=0, last_grant=3 (so requester 0 wins first), wait counter=0 and timeout_err=0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer immediately, with no further ack or tx_start.
REQ-033 After reset the block SHALL wait for tx_done to clear regardless of its level.

Verification
REQ-034 Single request: req=4'b0100, req_data[23:16]=8'hA5 -> next tick ack=4'b0100, tx_start=1, tx_data=8'hA5, grant_id=2; next start no earlier than 1 tick after tx_done rises.
REQ-035 Round-robin: req=4'b1111 held, transmitter model attached -> bytes sent from requesters 0,1,2,3,0 in order, one ack pulse each.
REQ-036 Stale done: tx_done held 1 from the previous byte, transmitter delays clearing by 3 ticks -> block stays in S_WAIT_CLR, no S_GAP and no second tx_start.
REQ-037 Timeout: TIMEOUT=16, tx_done stuck 1 -> timeout_err=1 after 16 ticks in S_WAIT_CLR, busy=0 next tick, then the next request is served.
REQ-038 Reset mid-operation: rst_n=0 for 1 tick during S_WAIT_DONE -> all outputs at reset values, then req=4'b0010 and req=4'b0001 together -> requester 0 granted first.
REQ-039 Simultaneous events: req[3] rises on the S_GAP tick while req[1] is pending and last_grant=0 -> requester 1 granted before requester 3.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters / UART transmitter (master side)
// and the transmit arbiter (slave side).
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        timeout_err;

    modport master (
        output req, req_data, tx_done,
        input  ack, grant_id, busy, tx_start, tx_data, timeout_err
    );

    modport slave (
        input  req, req_data, tx_done,
        output ack, grant_id, busy, tx_start, tx_data, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from four byte requesters.
// Each grant runs start, wait for done to clear, wait for done to set, one-tick gap.
module uart_tx_arbiter #(
    parameter int          N_REQ   = 4,
    parameter logic [15:0] TIMEOUT = 16'd2000
) (
    input  logic             i_tick,
    input  logic             i_rst_n,
    uart_tx_arbiter_if.slave io_bus
);
    // state       | meaning
    // S_IDLE      | arbitrate among pending requests
    // S_START     | tx_start high for one tick with the granted byte
    // S_WAIT_CLR  | wait for the transmitter to drop tx_done (start accepted)
    // S_WAIT_DONE | wait for tx_done to rise (stop bit reached)
    // S_GAP       | one tick so the transmitter is idle before the next start
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_CLR,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_ack;
    logic [1:0]  r_grant_id;
    logic [1:0]  r_last_grant;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic [15:0] r_wait_cnt;
    logic        r_timeout_err;

    logic        w_found;
    logic [1:0]  w_winner;
    logic [1:0]  w_idx;

    // Search upward from the requester after the last grant; first hit wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_grant;
        w_idx    = r_last_grant;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_found && io_bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge i_tick) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_ack         <= '0;
            r_grant_id    <= 2'd0;
            r_last_grant  <= 2'd3;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_tx_data       <= io_bus.req_data[{w_winner, 3'b000} +: 8];
                        r_grant_id      <= w_winner;
                        r_last_grant    <= w_winner;
                        r_ack[w_winner] <= 1'b1;
                        r_tx_start      <= 1'b1;
                        r_state         <= S_START;
                    end
                end
                S_START: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT_CLR;
                end
                // A tx_done still high from the previous byte is not completion.
                S_WAIT_CLR: begin
                    if (!io_bus.tx_done) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT_DONE;
                    end else if (r_wait_cnt == TIMEOUT - 16'd1) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (io_bus.tx_done) begin
                        r_state <= S_GAP;
                    end else if (r_wait_cnt == TIMEOUT - 16'd1) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.ack         = r_ack;
    assign io_bus.grant_id    = r_grant_id;
    assign io_bus.busy        = (r_state != S_IDLE);
    assign io_bus.tx_start    = r_tx_start;
    assign io_bus.tx_data     = r_tx_data;
    assign io_bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester and transmitter models plus a grant scoreboard.
module tb_uart_tx_arbiter;
    localparam logic [15:0] TB_TIMEOUT = 16'd16;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic tick;
    logic rst_n;

    uart_tx_arbiter_if u_if();

    uart_tx_arbiter #(
        .N_REQ   (4),
        .TIMEOUT (TB_TIMEOUT)
    ) u_dut (
        .i_tick  (tick),
        .i_rst_n (rst_n),
        .io_bus  (u_if)
    );

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   req_total[4];
    int   ack_count[4];
    int   clr_delay = 0;
    int   tx_len    = 6;
    bit   tx_stuck  = 1'b0;

    initial begin
        tick = 1'b0;
        forever #5 tick = ~tick;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic at_drive();
        @(posedge tick);
        #2;
    endtask

    task automatic at_sample();
        @(negedge tick);
        #2;
    endtask

    task automatic request(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = 2'(id);
        e.data = data;
        u_if.req_data[8*id +: 8] = data;
        req_total[id]++;
        sb.push_back(e);
    endtask

    task automatic wait_start(input int max_ticks);
        for (int k = 0; k < max_ticks; k++) begin
            at_sample();
            if (u_if.tx_start) break;
        end
        check_val("saw_start", u_if.tx_start, 1);
    endtask

    task automatic wait_idle(input int max_ticks);
        for (int k = 0; k < max_ticks; k++) begin
            at_sample();
            if (sb.size() == 0 && !u_if.busy) break;
        end
        check_val("sb_drained", sb.size(), 0);
        check_val("idle_busy", u_if.busy, 0);
    endtask

    // Transmitter: clears done clr_delay ticks after a start, sets it tx_len ticks later.
    initial begin : tx_model
        int clr_cnt;
        int len_cnt;
        bit active;
        clr_cnt = 0;
        len_cnt = 0;
        active  = 1'b0;
        u_if.tx_done = 1'b1;
        forever begin
            @(negedge tick);
            if (!rst_n) begin
                u_if.tx_done = 1'b1;
                active       = 1'b0;
            end else if (active) begin
                if (clr_cnt > 0) begin
                    clr_cnt--;
                    if (clr_cnt == 0) u_if.tx_done = 1'b0;
                end else begin
                    len_cnt--;
                    if (len_cnt <= 0) begin
                        u_if.tx_done = 1'b1;
                        active       = 1'b0;
                    end
                end
            end else if (u_if.tx_start && !tx_stuck) begin
                active  = 1'b1;
                clr_cnt = clr_delay;
                len_cnt = tx_len;
                if (clr_cnt == 0) u_if.tx_done = 1'b0;
            end
        end
    end

    // Requesters hold req until acked; grants are checked against the scoreboard.
    initial begin : monitor
        exp_t       e;
        logic       prev_done;
        logic [7:0] hold_data;
        bit         hold_valid;
        bit         have_rise;
        int         cyc;
        int         rise_cyc;
        prev_done  = 1'b1;
        hold_data  = '0;
        hold_valid = 1'b0;
        have_rise  = 1'b0;
        cyc        = 0;
        rise_cyc   = 0;
        for (int i = 0; i < 4; i++) ack_count[i] = 0;
        u_if.req = '0;
        forever begin
            @(negedge tick);
            #1;
            cyc++;
            if (!rst_n) begin
                have_rise  = 1'b0;
                hold_valid = 1'b0;
            end else begin
                if (!u_if.busy) hold_valid = 1'b0;
                if (hold_valid && u_if.ack == 4'd0)
                    check_val("tx_data_hold", u_if.tx_data, hold_data);
                if (u_if.tx_start)
                    check_val("ack_with_start", (u_if.ack != 4'd0), 1);
                if (u_if.ack != 4'd0) begin
                    if (sb.size() == 0) begin
                        check_val("ack_unexpected", u_if.ack, 0);
                    end else begin
                        e = sb.pop_front();
                        check_val("ack_onehot", u_if.ack, 32'(4'b0001 << e.id));
                        check_val("grant_id", u_if.grant_id, e.id);
                        check_val("tx_data", u_if.tx_data, e.data);
                        check_val("tx_start", u_if.tx_start, 1);
                        if (have_rise)
                            check_val("gap_after_done", (cyc - rise_cyc >= 3), 1);
                        hold_data  = e.data;
                        hold_valid = 1'b1;
                    end
                    for (int i = 0; i < 4; i++)
                        if (u_if.ack[i]) ack_count[i]++;
                end
                if (u_if.tx_done && !prev_done) begin
                    rise_cyc   = cyc;
                    have_rise  = 1'b1;
                    hold_valid = 1'b0;
                end
            end
            prev_done = u_if.tx_done;
            for (int i = 0; i < 4; i++)
                u_if.req[i] = (req_total[i] > ack_count[i]);
        end
    end

    initial begin : main
        rst_n         = 1'b0;
        u_if.req_data = '0;
        for (int i = 0; i < 4; i++) req_total[i] = 0;

        repeat (3) at_sample();
        check_val("rst_ack", u_if.ack, 0);
        check_val("rst_tx_start", u_if.tx_start, 0);
        check_val("rst_tx_data", u_if.tx_data, 0);
        check_val("rst_grant_id", u_if.grant_id, 0);
        check_val("rst_busy", u_if.busy, 0);
        check_val("rst_timeout_err", u_if.timeout_err, 0);

        at_drive();
        rst_n = 1'b1;
        repeat (3) at_sample();
        check_val("idle_no_req_busy", u_if.busy, 0);
        check_val("idle_no_req_start", u_if.tx_start, 0);

        // All four requesting: order 0,1,2,3,0.
        at_drive();
        request(0, 8'h10);
        request(1, 8'h21);
        request(2, 8'h32);
        request(3, 8'h43);
        request(0, 8'h10);
        wait_idle(300);
        check_val("rr_last_grant", u_if.grant_id, 0);

        // Single request, one-tick latency.
        at_drive();
        request(2, 8'hA5);
        at_sample();
        check_val("single_req_seen", u_if.req, 4'b0100);
        check_val("single_no_start_yet", u_if.tx_start, 0);
        at_sample();
        check_val("single_start", u_if.tx_start, 1);
        check_val("single_ack", u_if.ack, 4'b0100);
        check_val("single_grant", u_if.grant_id, 2);
        check_val("single_data", u_if.tx_data, 8'hA5);
        wait_idle(100);

        // Stale done: transmitter takes 3 ticks to clear; byte source changes after grant.
        clr_delay = 3;
        at_drive();
        request(1, 8'h3C);
        wait_start(10);
        at_drive();
        u_if.req_data[15:8] = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            at_sample();
            check_val("stale_busy", u_if.busy, 1);
            check_val("stale_no_start", u_if.tx_start, 0);
        end
        wait_idle(100);
        clr_delay = 0;

        // req[3] rises in S_GAP while req[1] pending with last grant 0.
        at_drive();
        request(0, 8'h5A);
        wait_start(20);
        at_drive();
        request(1, 8'h61);
        for (int k = 0; k < 40; k++) begin
            at_sample();
            if (u_if.tx_done) break;
        end
        check_val("done_seen", u_if.tx_done, 1);
        at_drive();
        check_val("gap_busy", u_if.busy, 1);
        request(3, 8'h73);
        wait_idle(200);

        // Timeout with tx_done stuck high.
        tx_stuck = 1'b1;
        at_drive();
        request(3, 8'h99);
        wait_start(20);
        repeat (16) at_sample();
        check_val("to_err_early", u_if.timeout_err, 0);
        check_val("to_busy_early", u_if.busy, 1);
        at_sample();
        check_val("to_err_set", u_if.timeout_err, 1);
        check_val("to_busy_clear", u_if.busy, 0);
        at_drive();
        tx_stuck = 1'b0;
        request(0, 8'h42);
        wait_idle(100);
        check_val("to_err_sticky", u_if.timeout_err, 1);

        // Reset during S_WAIT_DONE.
        tx_len = 10;
        at_drive();
        request(1, 8'hB7);
        wait_start(20);
        repeat (4) at_sample();
        check_val("mid_busy", u_if.busy, 1);
        check_val("mid_done_low", u_if.tx_done, 0);
        at_drive();
        rst_n = 1'b0;
        at_drive();
        rst_n = 1'b1;
        check_val("mid_rst_ack", u_if.ack, 0);
        check_val("mid_rst_start", u_if.tx_start, 0);
        check_val("mid_rst_data", u_if.tx_data, 0);
        check_val("mid_rst_grant", u_if.grant_id, 0);
        check_val("mid_rst_busy", u_if.busy, 0);
        check_val("mid_rst_err", u_if.timeout_err, 0);
        request(0, 8'hC0);
        request(1, 8'hC1);
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
